// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for the sequential ALU and its divider.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_DIV = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_XOR = 3'b110,
        OP_SHL = 3'b111
    } alu_op_e;

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        MUL,
        DIV,
        FIX,
        DONE
    } alu_state_e;

endpackage

// File: rtl/alu_seq_param_if.sv
// Request/response bundle between the operand stage (master) and the ALU (slave).
interface alu_seq_param_if #(
    parameter int W = 8
);
    logic           start;
    logic [2:0]     op;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] result;
    logic           err;

    modport master (
        output start, op, in_a, in_b,
        input  busy, done, result, err
    );

    modport slave (
        input  start, op, in_a, in_b,
        output busy, done, result, err
    );
endinterface

// File: rtl/alu_div_unit.sv
// Restoring divider datapath on operand magnitudes; one quotient bit per step,
// signs applied combinationally while the fix strobe is high.
module alu_div_unit #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           i_load,
    input  logic           i_step,
    input  logic           i_fix,
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    output logic [2*W-1:0] o_result
);

    logic [W-1:0] r_quo;
    logic [W-1:0] r_rem;
    logic [W-1:0] r_div;
    logic         r_neg_q;
    logic         r_neg_r;

    logic [W:0]   w_shift;
    logic [W:0]   w_diff;
    logic         w_fits;
    logic [W-1:0] w_quo_fixed;
    logic [W-1:0] w_rem_fixed;

    // Remainder stays below the divisor magnitude (<= 2^(W-1)), so W+1 bits hold the shifted value.
    assign w_shift     = {r_rem, r_quo[W-1]};
    assign w_diff      = w_shift - {1'b0, r_div};
    assign w_fits      = ~w_diff[W];
    assign w_quo_fixed = r_neg_q ? -r_quo : r_quo;
    assign w_rem_fixed = r_neg_r ? -r_rem : r_rem;
    assign o_result    = i_fix ? {w_rem_fixed, w_quo_fixed} : '0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_quo   <= '0;
            r_rem   <= '0;
            r_div   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (i_load) begin
            r_quo   <= i_a[W-1] ? -i_a : i_a;
            r_rem   <= '0;
            r_div   <= i_b[W-1] ? -i_b : i_b;
            r_neg_q <= i_a[W-1] ^ i_b[W-1];
            r_neg_r <= i_a[W-1];
        end else if (i_step) begin
            r_rem <= w_fits ? w_diff[W-1:0] : w_shift[W-1:0];
            r_quo <= {r_quo[W-2:0], w_fits};
        end
    end

endmodule

// File: rtl/alu_seq_param.sv
// W-bit signed sequential ALU: single-cycle ADD/SUB/logic, shift-add MUL, restoring DIV.
// Define ALU_SHIFT_EN to make op 111 a logical left shift; otherwise it is flagged illegal.
module alu_seq_param
    import alu_pkg::*;
#(
    parameter  int W     = 8,
    localparam int CNT_W = $clog2(W) + 1
) (
    input  logic          clk,
    input  logic          reset,
    alu_seq_param_if.slave bus
);

    localparam int SH_W = $clog2(W);

    alu_state_e     r_state;
    alu_state_e     w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    alu_op_e        r_op;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [2*W-1:0] r_acc;
    logic [2*W-1:0] r_mcand;
    logic [W-1:0]   r_mplier;
    logic           r_neg;
    logic [2*W-1:0] r_result;
    logic           r_err;

    logic           w_accept;
    logic           w_last;
    logic           w_div_load;
    logic           w_div_step;
    logic           w_div_fix;
    logic [2*W-1:0] w_ext_a;
    logic [2*W-1:0] w_ext_b;
    logic [2*W-1:0] w_exec_result;
    logic           w_exec_err;
    logic [2*W-1:0] w_mul_sum;
    logic [2*W-1:0] w_mul_final;
    logic [2*W-1:0] w_div_result;

    assign w_accept = (r_state == IDLE) && bus.start;
    assign w_last   = (r_cnt == CNT_W'(W));
    assign w_ext_a  = {{W{r_a[W-1]}}, r_a};
    assign w_ext_b  = {{W{r_b[W-1]}}, r_b};

    assign w_mul_sum   = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_mul_final = r_neg ? -w_mul_sum : w_mul_sum;

    assign bus.busy   = (r_state != IDLE);
    assign bus.done   = (r_state == DONE);
    assign bus.result = r_result;
    assign bus.err    = r_err;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_div_load  = 1'b0;
        w_div_step  = 1'b0;
        w_div_fix   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    case (alu_op_e'(bus.op))
                        OP_MUL:  w_state_nxt = MUL;
                        OP_DIV:  w_state_nxt = (bus.in_b == '0) ? EXEC : DIV;
                        default: w_state_nxt = EXEC;
                    endcase
                end
            end
            EXEC: w_state_nxt = DONE;
            MUL:  if (w_last) w_state_nxt = DONE;
            DIV: begin
                w_div_load = (r_cnt == '0);
                w_div_step = (r_cnt != '0);
                if (w_last) w_state_nxt = FIX;
            end
            FIX: begin
                w_div_fix   = 1'b1;
                w_state_nxt = DONE;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Divide-by-zero and illegal ops share the single-cycle EXEC path.
    always_comb begin
        w_exec_result = '0;
        w_exec_err    = 1'b0;
        case (r_op)
            OP_ADD: w_exec_result = w_ext_a + w_ext_b;
            OP_SUB: w_exec_result = w_ext_a - w_ext_b;
            OP_AND: w_exec_result = {{W{1'b0}}, r_a & r_b};
            OP_OR:  w_exec_result = {{W{1'b0}}, r_a | r_b};
            OP_XOR: w_exec_result = {{W{1'b0}}, r_a ^ r_b};
            OP_DIV: begin
                w_exec_result = {r_a, {W{1'b1}}};
                w_exec_err    = 1'b1;
            end
            OP_SHL: begin
`ifdef ALU_SHIFT_EN
                w_exec_result = {{W{1'b0}}, r_a} << r_b[SH_W-1:0];
`else
                w_exec_err    = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    alu_div_unit #(.W(W)) u_div (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_div_load),
        .i_step   (w_div_step),
        .i_fix    (w_div_fix),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_result (w_div_result)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_op     <= OP_ADD;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op <= alu_op_e'(bus.op);
                r_a  <= bus.in_a;
                r_b  <= bus.in_b;
            end
            r_cnt <= ((r_state == MUL || r_state == DIV) && !w_last) ? r_cnt + CNT_W'(1) : '0;
            case (r_state)
                EXEC: begin
                    r_result <= w_exec_result;
                    r_err    <= w_exec_err;
                end
                // Counter 0 loads magnitudes; counts 1..W are the W shift-add steps.
                MUL: begin
                    if (r_cnt == '0) begin
                        r_acc    <= '0;
                        r_mcand  <= {{W{1'b0}}, (r_a[W-1] ? -r_a : r_a)};
                        r_mplier <= r_b[W-1] ? -r_b : r_b;
                        r_neg    <= r_a[W-1] ^ r_b[W-1];
                    end else begin
                        r_acc    <= w_mul_sum;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                    end
                    if (w_last) begin
                        r_result <= w_mul_final;
                        r_err    <= 1'b0;
                    end
                end
                FIX: begin
                    r_result <= w_div_result;
                    r_err    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_param.sv
// Self-checking bench for alu_seq_param (W=8): directed corner cases plus random ops
// compared against an integer-arithmetic reference model.
module tb_alu_seq_param;
    import alu_pkg::*;

    localparam int W  = 8;
    localparam int RW = 2 * W;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    alu_seq_param_if #(.W(W)) bus ();

    alu_seq_param #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: signed integer arithmetic, SV division truncates toward zero with dividend-signed remainder.
    function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [RW-1:0] res, output logic err, output int lat);
        int sa, sb, q, r;
        sa  = $signed(a);
        sb  = $signed(b);
        res = '0;
        err = 1'b0;
        lat = 2;
        case (op)
            3'b000: res = RW'(sa + sb);
            3'b001: res = RW'(sa - sb);
            3'b010: begin res = RW'(sa * sb); lat = W + 2; end
            3'b011: begin
                if (sb == 0) begin
                    res = {a, {W{1'b1}}};
                    err = 1'b1;
                end else begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {W'(r), W'(q)};
                    lat = W + 3;
                end
            end
            3'b100: res = RW'(int'(a) & int'(b));
            3'b101: res = RW'(int'(a) | int'(b));
            3'b110: res = RW'(int'(a) ^ int'(b));
            default: begin
`ifdef ALU_SHIFT_EN
                res = RW'(int'(a) * (1 << (int'(b) % W)));
`else
                err = 1'b1;
`endif
            end
        endcase
    endfunction

    // poke > 0: pulse start with junk operands after that many cycles; start_in_done: hold start in DONE.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int poke, input bit start_in_done);
        logic [RW-1:0] exp_res;
        logic          exp_err;
        int            exp_lat;
        int            cyc;
        bit            seen;
        model(op, a, b, exp_res, exp_err, exp_lat);
        bus.op    = op;
        bus.in_a  = a;
        bus.in_b  = b;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.in_a  = ~a;
        bus.in_b  = ~b;
        cyc  = 1;
        seen = 1'b0;
        check({tag, ".busy_after_accept"}, RW'(bus.busy), RW'(1));
        while (!seen && cyc < 40) begin
            if (cyc == poke) begin
                bus.start = 1'b1;
                bus.op    = 3'($urandom);
                bus.in_a  = W'($urandom);
                bus.in_b  = W'($urandom);
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            cyc++;
            if (bus.done) seen = 1'b1;
        end
        check({tag, ".latency"}, RW'(cyc), RW'(exp_lat));
        check({tag, ".result"}, bus.result, exp_res);
        check({tag, ".err"}, RW'(bus.err), RW'(exp_err));
        check({tag, ".busy_in_done"}, RW'(bus.busy), RW'(1));
        if (start_in_done) begin
            bus.start = 1'b1;
            bus.op    = 3'b000;
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        check({tag, ".idle_busy"}, RW'(bus.busy), RW'(0));
        check({tag, ".idle_done"}, RW'(bus.done), RW'(0));
        check({tag, ".held_result"}, bus.result, exp_res);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_done;
        logic [2:0]   r_op;
        logic [W-1:0] r_a, r_b;
        int           poke;

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.in_a  = '0;
        bus.in_b  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.busy", RW'(bus.busy), RW'(0));
        check("reset.done", RW'(bus.done), RW'(0));
        check("reset.result", bus.result, RW'(0));
        check("reset.err", RW'(bus.err), RW'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        run_op("add_25_17",      3'b000, 8'd25,  8'd17, -1, 1'b0);
        run_op("sub_42_15",      3'b001, 8'd42,  8'd15, -1, 1'b0);
        run_op("sub_m128_127",   3'b001, 8'h80,  8'h7F, -1, 1'b1);
        run_op("mul_22_54",      3'b010, 8'd22,  8'd54, -1, 1'b0);
        run_op("mul_10_m5",      3'b010, 8'd10,  8'hFB, -1, 1'b0);
        run_op("mul_m10_m5",     3'b010, 8'hF6,  8'hFB, -1, 1'b0);
        run_op("mul_m128_m128",  3'b010, 8'h80,  8'h80, -1, 1'b0);
        run_op("div_m100_4",     3'b011, 8'h9C,  8'd4,  -1, 1'b0);
        run_op("div_m7_2",       3'b011, 8'hF9,  8'd2,  -1, 1'b0);
        run_op("div_m128_m1",    3'b011, 8'h80,  8'hFF, -1, 1'b0);
        run_op("div_10_0",       3'b011, 8'd10,  8'd0,  -1, 1'b0);
        run_op("and_aa_cc",      3'b100, 8'hAA,  8'hCC, -1, 1'b0);
        run_op("or_aa_cc",       3'b101, 8'hAA,  8'hCC, -1, 1'b0);
        run_op("xor_aa_cc",      3'b110, 8'hAA,  8'hCC, -1, 1'b0);
        run_op("op7_81_3",       3'b111, 8'h81,  8'd3,  -1, 1'b0);
        run_op("mul_start_poke", 3'b010, 8'd22,  8'd54,  4, 1'b0);
        run_op("div_start_done", 3'b011, 8'd100, 8'd7,   2, 1'b1);

        // Abort a divide mid-iteration: outputs clear and no done pulse follows.
        bus.op    = 3'b011;
        bus.in_a  = 8'h9C;
        bus.in_b  = 8'd4;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_mid_div.busy", RW'(bus.busy), RW'(0));
        check("rst_mid_div.done", RW'(bus.done), RW'(0));
        check("rst_mid_div.result", bus.result, RW'(0));
        check("rst_mid_div.err", RW'(bus.err), RW'(0));
        n_done = 0;
        repeat (W + 5) begin
            @(posedge clk); #1;
            if (bus.done) n_done++;
        end
        check("rst_mid_div.no_done", RW'(n_done), RW'(0));

        for (int i = 0; i < 80; i++) begin
            r_op = 3'($urandom_range(0, 7));
            r_a  = W'($urandom);
            r_b  = W'($urandom);
            if ($urandom_range(0, 5) == 0) r_b = '0;
            if ($urandom_range(0, 7) == 0) r_a = 8'h80;
            poke = -1;
            if ($urandom_range(0, 3) == 0) poke = int'($urandom_range(1, 3));
            run_op($sformatf("rand%0d", i), r_op, r_a, r_b, poke, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
